shift_arbiter: RTL and testbench

//  Shares one combinational shifter instance between two requesters: req0 (ALU issue) and req1 (address/immediate path).

---
 rtl/risc_pkg.sv | 30 +++
 rtl/shift_arbiter_shifter.sv | 25 ++
 rtl/shift_arbiter.sv | 112 +++++++++++
 tb/tb_shift_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/risc_pkg.sv
// Shared shifter request type and shift-direction/mode encodings.
// The helper maps an issued request onto the command the shifter actually sees.
package risc_pkg;

  localparam int RISC_DATA_W  = 32;
  localparam int RISC_SHAMT_W = 5;

  localparam logic SHIFT_LEFT    = 1'b1;
  localparam logic SHIFT_RIGHT   = 1'b0;
  localparam logic SHIFT_LOGICAL = 1'b1;
  localparam logic SHIFT_ARITH   = 1'b0;

  typedef struct packed {
    logic [RISC_DATA_W-1:0]  data;
    logic [RISC_SHAMT_W-1:0] shamt;
    logic                    left;
    logic                    logical;
  } shift_req_t;

  // A left shift has no arithmetic form, so it is always issued as logical-left.
  function automatic shift_req_t shifter_cmd(input shift_req_t req);
    shift_req_t cmd;
    cmd = req;
    if (req.left == SHIFT_LEFT) begin
      cmd.logical = SHIFT_LOGICAL;
    end
    return cmd;
  endfunction

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Purely combinational barrel shifter: left, logical-right or arithmetic-right.
// Zero latency; no flow control of its own.
module shift_arbiter_shifter #(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = 5
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               left,
  input  logic               logical,
  output logic [DATA_W-1:0]  result
);

  always_comb begin
    result = data;
    if (left) begin
      result = data << shamt;
    end else if (logical) begin
      result = data >> shamt;
    end else begin
      result = DATA_W'($signed(data) >>> shamt);
    end
  end

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin share of one shifter between two requesters, single registered response stage.
// One cycle from handshake to rsp_valid; a stalled response blocks all grants until consumed.
module shift_arbiter
  import risc_pkg::*;
#(
  parameter int DATA_W  = RISC_DATA_W,
  parameter int SHAMT_W = RISC_SHAMT_W,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic [SHAMT_W-1:0] req0_shamt,
  input  logic               req0_left,
  input  logic               req0_logical,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_data,
  input  logic [SHAMT_W-1:0] req1_shamt,
  input  logic               req1_left,
  input  logic               req1_logical,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [DATA_W-1:0]  rsp_data,
  output logic               rsp_id,
  output logic [CNT_W-1:0]   ops_done
);

  localparam logic [0:0] ST_EMPTY = 1'b0;
  localparam logic [0:0] ST_FULL  = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              rsp_id_q, rsp_id_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]  ops_done_q, ops_done_d;

  logic              can_accept;
  logic              gnt_vld;
  logic              gnt_id;
  logic              consume;
  shift_req_t        req0_op, req1_op, sel_op, shf_op;
  logic [DATA_W-1:0] shf_result;

  assign consume    = (state_q == ST_FULL) && rsp_ready;
  assign can_accept = (state_q == ST_EMPTY) || consume;

  // Contention goes to the rr_ptr side; otherwise whichever side is valid.
  assign gnt_vld = rst_n && can_accept && (req0_valid || req1_valid);
  assign gnt_id  = (req0_valid && req1_valid) ? rr_ptr_q : req1_valid;

  assign req0_ready = gnt_vld && !gnt_id;
  assign req1_ready = gnt_vld &&  gnt_id;

  assign req0_op = '{data: req0_data, shamt: req0_shamt, left: req0_left, logical: req0_logical};
  assign req1_op = '{data: req1_data, shamt: req1_shamt, left: req1_left, logical: req1_logical};
  assign sel_op  = gnt_id ? req1_op : req0_op;
  assign shf_op  = shifter_cmd(sel_op);

  shift_arbiter_shifter #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .data    (shf_op.data),
    .shamt   (shf_op.shamt),
    .left    (shf_op.left),
    .logical (shf_op.logical),
    .result  (shf_result)
  );

  always_comb begin
    state_d    = state_q;
    rsp_data_d = rsp_data_q;
    rsp_id_d   = rsp_id_q;
    rr_ptr_d   = rr_ptr_q;
    ops_done_d = ops_done_q;
    if (consume) begin
      ops_done_d = ops_done_q + CNT_W'(1);
      state_d    = ST_EMPTY;
    end
    if (gnt_vld) begin
      state_d    = ST_FULL;
      rsp_data_d = shf_result;
      rsp_id_d   = gnt_id;
      rr_ptr_d   = ~gnt_id;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_EMPTY;
      rsp_data_q <= '0;
      rsp_id_q   <= 1'b0;
      rr_ptr_q   <= 1'b0;
      ops_done_q <= '0;
    end else begin
      state_q    <= state_d;
      rsp_data_q <= rsp_data_d;
      rsp_id_q   <= rsp_id_d;
      rr_ptr_q   <= rr_ptr_d;
      ops_done_q <= ops_done_d;
    end
  end

  assign rsp_valid = (state_q == ST_FULL);
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign ops_done  = ops_done_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed bench for shift_arbiter: reset, op mapping, round-robin, backpressure, counter wrap.
module tb_shift_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0_valid, req0_ready, req0_left, req0_logical;
  logic [31:0] req0_data;
  logic [4:0]  req0_shamt;
  logic        req1_valid, req1_ready, req1_left, req1_logical;
  logic [31:0] req1_data;
  logic [4:0]  req1_shamt;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_data;
  logic [15:0] ops_done;

  int checks   = 0;
  int failures = 0;

  shift_arbiter #(.DATA_W(32), .SHAMT_W(5), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req0_valid   (req0_valid),
    .req0_ready   (req0_ready),
    .req0_data    (req0_data),
    .req0_shamt   (req0_shamt),
    .req0_left    (req0_left),
    .req0_logical (req0_logical),
    .req1_valid   (req1_valid),
    .req1_ready   (req1_ready),
    .req1_data    (req1_data),
    .req1_shamt   (req1_shamt),
    .req1_left    (req1_left),
    .req1_logical (req1_logical),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_id       (rsp_id),
    .ops_done     (ops_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h0; req0_shamt = 5'd0; req0_left = 1'b0; req0_logical = 1'b1;
    req1_valid = 1'b1; req1_data = 32'h0; req1_shamt = 5'd0; req1_left = 1'b0; req1_logical = 1'b1;

    // Reset with traffic pending
    repeat (3) step();
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rsp_data", rsp_data, 32'h0);
    chk("rst_rsp_id", {31'd0, rsp_id}, 32'd0);
    chk("rst_ops_done", {16'd0, ops_done}, 32'd0);
    chk("rst_req0_ready", {31'd0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'd0, req1_ready}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rel_req0_ready", {31'd0, req0_ready}, 32'd1);
    chk("rel_req1_ready", {31'd0, req1_ready}, 32'd0);
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("drop_req0_ready", {31'd0, req0_ready}, 32'd0);
    step();
    chk("drop_no_rsp", {31'd0, rsp_valid}, 32'd0);

    // Single req0, arithmetic right
    req0_valid = 1'b1; req0_data = 32'h8000_0001; req0_shamt = 5'd4; req0_left = 1'b0; req0_logical = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("t2_req0_ready", {31'd0, req0_ready}, 32'd1);
    step();
    req0_valid = 1'b0;
    chk("t2_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("t2_rsp_data", rsp_data, 32'hF800_0000);
    chk("t2_rsp_id", {31'd0, rsp_id}, 32'd0);
    step();
    chk("t2_drain_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t2_ops_done", {16'd0, ops_done}, 32'd1);

    // Op mapping on req1
    req1_valid = 1'b1; req1_data = 32'h8000_0001; req1_shamt = 5'd1; req1_left = 1'b0; req1_logical = 1'b1;
    step();
    chk("t3_lsr_data", rsp_data, 32'h4000_0000);
    chk("t3_lsr_id", {31'd0, rsp_id}, 32'd1);
    req1_left = 1'b1; req1_logical = 1'b0;
    step();
    chk("t3_asl_data", rsp_data, 32'h0000_0002);
    req1_left = 1'b1; req1_logical = 1'b1;
    step();
    chk("t3_lsl_data", rsp_data, 32'h0000_0002);
    req1_valid = 1'b0;
    step();
    chk("t3_drain_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t3_ops_done", {16'd0, ops_done}, 32'd4);

    // Round-robin with both valid, shamt=0 passes data through
    req0_valid = 1'b1; req0_data = 32'h1234_5678; req0_shamt = 5'd0; req0_left = 1'b0; req0_logical = 1'b1;
    req1_valid = 1'b1; req1_data = 32'hCAFE_0000; req1_shamt = 5'd0; req1_left = 1'b1; req1_logical = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk($sformatf("t4_id_%0d", i), {31'd0, rsp_id}, (i % 2 == 0) ? 32'd0 : 32'd1);
      chk($sformatf("t4_data_%0d", i), rsp_data, (i % 2 == 0) ? 32'h1234_5678 : 32'hCAFE_0000);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("t4_ops_done", {16'd0, ops_done}, 32'd10);

    // Backpressure with both valid; max shift amounts
    req0_valid = 1'b1; req0_data = 32'h8000_0000; req0_shamt = 5'd31; req0_left = 1'b0; req0_logical = 1'b0;
    req1_valid = 1'b1; req1_data = 32'h0000_0001; req1_shamt = 5'd31; req1_left = 1'b1; req1_logical = 1'b1;
    rsp_ready = 1'b0;
    #1;
    chk("t5_first_req0_ready", {31'd0, req0_ready}, 32'd1);
    step();
    chk("t5_rsp_data", rsp_data, 32'hFFFF_FFFF);
    chk("t5_rsp_id", {31'd0, rsp_id}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) req1_valid = 1'b0;
      if (i == 2) req1_valid = 1'b1;
      #1;
      chk($sformatf("t5_stall_ready0_%0d", i), {31'd0, req0_ready}, 32'd0);
      chk($sformatf("t5_stall_ready1_%0d", i), {31'd0, req1_ready}, 32'd0);
      step();
      chk($sformatf("t5_stall_valid_%0d", i), {31'd0, rsp_valid}, 32'd1);
      chk($sformatf("t5_stall_data_%0d", i), rsp_data, 32'hFFFF_FFFF);
      chk($sformatf("t5_stall_id_%0d", i), {31'd0, rsp_id}, 32'd0);
    end
    rsp_ready = 1'b1;
    #1;
    chk("t5_release_ready1", {31'd0, req1_ready}, 32'd1);
    chk("t5_release_ready0", {31'd0, req0_ready}, 32'd0);
    step();
    chk("t5_next_id", {31'd0, rsp_id}, 32'd1);
    chk("t5_next_data", rsp_data, 32'h8000_0000);
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("t5_ops_done", {16'd0, ops_done}, 32'd12);

    // Reset asserted while a response is pending
    req0_valid = 1'b1; req0_data = 32'h0000_00F0; req0_shamt = 5'd4; req0_left = 1'b0; req0_logical = 1'b1;
    rsp_ready = 1'b0;
    step();
    chk("t6_pending_valid", {31'd0, rsp_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_midrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("t6_midrst_ops", {16'd0, ops_done}, 32'd0);
    chk("t6_midrst_ready0", {31'd0, req0_ready}, 32'd0);
    req0_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("t6_after_rel_valid", {31'd0, rsp_valid}, 32'd0);

    // Counter wrap: 65536 back-to-back grants give 65535 consumes
    req0_valid = 1'b1; req0_data = 32'h0000_0005; req0_shamt = 5'd0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 65536; i++) step();
    chk("t7_ops_ffff", {16'd0, ops_done}, 32'h0000_FFFF);
    step();
    chk("t7_ops_wrap", {16'd0, ops_done}, 32'h0000_0000);
    chk("t7_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    req0_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
